// File: rtl/miter_sweep_pkg.sv
// rtl/miter_sweep_pkg.sv - shared state type, limits and sweep-length helper for miter_sweep_ctrl
package miter_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam int NIN_MAX = 16;
  localparam int LAT_MAX = 3;

  function automatic int unsigned sweep_len(input int unsigned nin);
    return 32'd1 << nin;
  endfunction

endpackage

// File: rtl/miter_sweep_ctrl_delay_line.sv
// rtl/miter_sweep_ctrl_delay_line.sv - LAT-deep {valid, vector} shift register aligning issued vectors with netlist responses
module sweep_delay_line #(
  parameter int W   = 12,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_vec,
  output logic         tap_valid,
  output logic [W-1:0] tap_vec,
  output logic         inflight
);

  generate
    if (LAT == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = clk ^ clr;
      assign tap_valid   = in_valid;
      assign tap_vec     = in_vec;
      assign inflight    = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0] vld;
      logic [W-1:0]   vecs [LAT];

      always_ff @(posedge clk) begin
        if (clr) begin
          vld <= '0;
          for (int i = 0; i < LAT; i++) vecs[i] <= '0;
        end else begin
          vld[0]  <= in_valid;
          vecs[0] <= in_vec;
          for (int i = 1; i < LAT; i++) begin
            vld[i]  <= vld[i-1];
            vecs[i] <= vecs[i-1];
          end
        end
      end

      assign tap_valid = vld[LAT-1];
      assign tap_vec   = vecs[LAT-1];

      // Entries still upstream of the tap; once clear, the tap holds the last sample.
      if (LAT == 1) begin : g_one
        assign inflight = 1'b0;
      end else begin : g_many
        assign inflight = |vld[LAT-2:0];
      end
    end
  endgenerate

endmodule

// File: rtl/miter_sweep_ctrl.sv
// rtl/miter_sweep_ctrl.sv - exhaustive miter sweep sequencer; optional EARLY_STOP_EN ends the sweep at the first mismatch
module miter_sweep_ctrl
  import miter_sweep_pkg::*;
#(
  parameter int NIN = 12,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [NIN-1:0] vec_o,
  input  logic           f_impl_i,
  input  logic           f_gold_i,
  output logic           busy,
  output logic           done,
  output logic           equal,
  output logic [NIN-1:0] mismatch_vec,
  output logic [NIN:0]   ones_cnt
);

  localparam logic [NIN-1:0] VEC_MAX = NIN'(sweep_len(NIN) - 1);

  sweep_state_t   state, state_nxt;
  logic           flag;
  logic           accept;
  logic           sample_miss;
  logic           stop;
  logic           line_clr;
  logic           tap_valid;
  logic [NIN-1:0] tap_vec;
  logic           inflight;

  assign accept      = start && ((state == IDLE) || (state == DONE));
  assign sample_miss = tap_valid && (f_impl_i != f_gold_i) && !flag;

`ifdef EARLY_STOP_EN
  assign stop = sample_miss;
`else
  assign stop = 1'b0;
`endif

  // Stopping early flushes in-flight samples so they are never counted.
  assign line_clr = rst || accept || stop;

  sweep_delay_line #(
    .W   (NIN),
    .LAT (LAT)
  ) u_line (
    .clk       (clk),
    .clr       (line_clr),
    .in_valid  (state == SWEEP),
    .in_vec    (vec_o),
    .tap_valid (tap_valid),
    .tap_vec   (tap_vec),
    .inflight  (inflight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    equal     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (stop) begin
          state_nxt = DONE;
        end else if (vec_o == VEC_MAX) begin
          state_nxt = (LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (stop || !inflight) state_nxt = DONE;
      end
      DONE: begin
        done  = 1'b1;
        equal = !flag;
        if (accept) state_nxt = SWEEP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_o        <= '0;
      flag         <= 1'b0;
      mismatch_vec <= '0;
      ones_cnt     <= '0;
    end else if (accept) begin
      vec_o        <= '0;
      flag         <= 1'b0;
      mismatch_vec <= '0;
      ones_cnt     <= '0;
    end else begin
      // vec_o parks on the last vector (or the stop point) instead of wrapping.
      if ((state == SWEEP) && !stop && (vec_o != VEC_MAX)) begin
        vec_o <= vec_o + NIN'(1);
      end
      if (tap_valid) begin
        ones_cnt <= ones_cnt + (NIN+1)'(f_impl_i);
      end
      if (sample_miss) begin
        flag         <= 1'b1;
        mismatch_vec <= tap_vec;
      end
    end
  end

endmodule
